data_mem_responder: RTL and testbench

- Data-memory slave at the far end of the memory-stage load/store interface.
- Accepts one request at a time over a valid/ready handshake and applies a byte-masked write or a word read.
- Returns a response after a fixed programmable latency, held until the requester accepts it.
- Gives the pipeline a multi-cycle memory model, so stall logic can be exercised in place of the zero-latency array.

---
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory-stage load/store port.
// Takes one request at a time over a valid/ready handshake. Each request is
// either a byte-masked store or a word load. The response appears after
// LATENCY cycles and is held until the requester accepts it.
// Memory word i resets to the value i.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   // The wait counter runs from LATENCY-2 down to 0 while the FSM is in WAIT.
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : CNT_W'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;

   logic [31:0]       mem_r [DEPTH];

   logic [AW-1:0]     idx_s;
   logic              addr_err_s;
   logic              accept_s;
   logic              mem_we_s;
   logic [31:0]       rd_word_s;
   logic [31:0]       fresh_rdata_s;

   // The snapshot is taken at acceptance. It is copied to the outputs only on entry to RESP,
   // so rsp_rdata stays 0 while no response is presented.
   logic [31:0]       snap_rdata_r;
   logic              snap_err_r;

   logic              rsp_valid_r;
   logic [31:0]       rsp_rdata_r;
   logic              rsp_err_r;
   logic              rsp_valid_nxt_s;
   logic [31:0]       rsp_rdata_nxt_s;
   logic              rsp_err_nxt_s;

   // Address decode. Bits above the word index must be zero. The byte offset must be zero.
   assign idx_s      = req_addr[AW+1:2];
   assign addr_err_s = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);

   // Ready is held low while reset is asserted.
   assign req_ready  = (state_r == IDLE) && !reset;
   assign accept_s   = req_valid && req_ready;
   assign mem_we_s   = accept_s && req_we && !addr_err_s;

   // Load data is returned only for an in-range load. A store or an error returns zero.
   assign rd_word_s     = mem_r[idx_s];
   assign fresh_rdata_s = (addr_err_s || req_we) ? 32'd0 : rd_word_s;

   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   // Memory array: reset to word i = i, and apply byte-lane writes when a store is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'(i);
         end
      end else if (mem_we_s) begin
         for (int k = 0; k < 4; k++) begin
            if (req_be[k]) begin
               mem_r[idx_s][8*k +: 8] <= req_wdata[8*k +: 8];
            end
         end
      end
   end

   // Next-state, counter and response-output logic.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      rsp_valid_nxt_s = 1'b0;
      rsp_rdata_nxt_s = 32'd0;
      rsp_err_nxt_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (LATENCY == 1) begin
                  state_nxt_s = RESP;
               end else begin
                  state_nxt_s = WAIT;
                  cnt_nxt_s   = CNT_LOAD;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == CNT_W'(0)) begin
               state_nxt_s = RESP;
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_W'(0);
         end
      endcase

      // With LATENCY = 1, IDLE goes straight to RESP, so that path uses the freshly decoded data.
      if (state_nxt_s == RESP) begin
         rsp_valid_nxt_s = 1'b1;
         if (state_r == IDLE) begin
            rsp_rdata_nxt_s = fresh_rdata_s;
            rsp_err_nxt_s   = addr_err_s;
         end else begin
            rsp_rdata_nxt_s = snap_rdata_r;
            rsp_err_nxt_s   = snap_err_r;
         end
      end else begin
         rsp_valid_nxt_s = 1'b0;
      end
   end

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= CNT_W'(0);
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Capture the request's read data and error flag at the acceptance edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_rdata_r <= 32'd0;
         snap_err_r   <= 1'b0;
      end else if (accept_s) begin
         snap_rdata_r <= fresh_rdata_s;
         snap_err_r   <= addr_err_s;
      end
   end

   // Registered response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
// Instance dut_a uses LATENCY = 2 and instance dut_b uses LATENCY = 1.
// Every expected value in this file is hand-computed.
module tb_data_mem_responder;

   localparam int LAT_A = 2;

   logic        clk;
   logic        reset;

   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [3:0]  a_req_be;

   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_be;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_n    = 0;
   int acc_t [4];

   data_mem_responder #(.DEPTH(1024), .LATENCY(LAT_A)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_be(a_req_be), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_be(b_req_be), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter used to time acceptances on dut_b
   always @(posedge clk) cyc <= cyc + 1;

   // record dut_b acceptance cycles (sampled away from the active edge)
   always @(negedge clk) begin
      if (b_req_valid && b_req_ready && acc_n < 4) begin
         acc_t[acc_n] = cyc;
         acc_n++;
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete transaction on dut_a.
   // hold = number of cycles rsp_ready is held low once the response is presented.
   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int g;
      int lat;
      @(negedge clk);
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_be    = be;
      a_req_wdata = wdata;
      a_req_valid = 1'b1;
      a_rsp_ready = 1'b0;
      g = 0;
      while (!a_req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      check({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      a_req_addr  = 32'hDEAD_BEE0;
      a_req_wdata = 32'h1234_5678;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!a_rsp_valid && lat < 20);
      check({tag, "_latency"}, 32'(lat), 32'(LAT_A));
      for (int h = 0; h < hold; h++) begin
         // a request offered while the response is pending must have no effect
         a_req_valid = 1'b1;
         a_req_we    = 1'b1;
         a_req_addr  = addr;
         a_req_be    = 4'hF;
         a_req_wdata = 32'h0000_0000;
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(a_rsp_valid), 32'd1);
         check({tag, "_hold_rdata"}, a_rsp_rdata, exp_rdata);
         check({tag, "_hold_ready"}, 32'(a_req_ready), 32'd0);
      end
      a_req_valid = 1'b0;
      a_rsp_ready = 1'b1;
      check({tag, "_rdata"}, a_rsp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(a_rsp_err), 32'(exp_err));
      @(negedge clk);
      check({tag, "_post_valid"}, 32'(a_rsp_valid), 32'd0);
      check({tag, "_post_rdata"}, a_rsp_rdata, 32'd0);
      check({tag, "_post_err"}, 32'(a_rsp_err), 32'd0);
      check({tag, "_post_ready"}, 32'(a_req_ready), 32'd1);
      a_rsp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_be = 4'h0;
      a_req_wdata = 32'd0; a_rsp_ready = 1'b0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_be = 4'h0;
      b_req_wdata = 32'd0; b_rsp_ready = 1'b0;

      // outputs while reset is held
      #3;
      check("rst_req_ready", 32'(a_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rel_req_ready", 32'(a_req_ready), 32'd1);

      // 1: load from reset contents
      xact("t1_load10", 1'b0, 32'h0000_0010, 4'h0, 32'd0, 0, 32'h0000_0004, 1'b0);

      // 2: byte-masked store, then read back
      xact("t2_store20", 1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 0, 32'd0, 1'b0);
      xact("t2_load20", 1'b0, 32'h0000_0020, 4'h0, 32'd0, 0, 32'h00BB_00DD, 1'b0);
      xact("t2_store24_be0", 1'b1, 32'h0000_0024, 4'b0000, 32'hFFFF_FFFF, 0, 32'd0, 1'b0);
      xact("t2_load24", 1'b0, 32'h0000_0024, 4'h0, 32'd0, 0, 32'h0000_0009, 1'b0);

      // 3: errors, no corruption, last word
      xact("t3_load1000", 1'b0, 32'h0000_1000, 4'h0, 32'd0, 0, 32'd0, 1'b1);
      xact("t3_load6", 1'b0, 32'h0000_0006, 4'h0, 32'd0, 0, 32'd0, 1'b1);
      xact("t3_store1000", 1'b1, 32'h0000_1000, 4'hF, 32'hCAFE_F00D, 0, 32'd0, 1'b1);
      xact("t3_store80000000", 1'b1, 32'h8000_0004, 4'hF, 32'hCAFE_F00D, 0, 32'd0, 1'b1);
      xact("t3_load0", 1'b0, 32'h0000_0000, 4'h0, 32'd0, 0, 32'd0, 1'b0);
      xact("t3_load4", 1'b0, 32'h0000_0004, 4'h0, 32'd0, 0, 32'h0000_0001, 1'b0);
      xact("t3_loadffc", 1'b0, 32'h0000_0FFC, 4'h0, 32'd0, 0, 32'h0000_03FF, 1'b0);

      // 4: back-pressure with ignored request pulses
      xact("t4_load0c_bp", 1'b0, 32'h0000_000C, 4'h0, 32'd0, 5, 32'h0000_0003, 1'b0);
      xact("t4_load0c_again", 1'b0, 32'h0000_000C, 4'h0, 32'd0, 0, 32'h0000_0003, 1'b0);

      // 5: LATENCY=1 instance, back-to-back loads with rsp_ready tied high
      @(posedge clk);
      #1;
      b_req_we = 1'b0; b_req_addr = 32'h0000_0004; b_req_valid = 1'b1; b_rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_ready0", 32'(b_req_ready), 32'd1);
      @(posedge clk);
      #1;
      b_req_addr = 32'h0000_0008;
      @(negedge clk);
      check("t5_valid1", 32'(b_rsp_valid), 32'd1);
      check("t5_rdata1", b_rsp_rdata, 32'h0000_0001);
      check("t5_busy", 32'(b_req_ready), 32'd0);
      @(negedge clk);
      check("t5_ready1", 32'(b_req_ready), 32'd1);
      check("t5_gap_valid", 32'(b_rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      @(negedge clk);
      check("t5_valid2", 32'(b_rsp_valid), 32'd1);
      check("t5_rdata2", b_rsp_rdata, 32'h0000_0002);
      check("t5_err2", 32'(b_rsp_err), 32'd0);
      @(negedge clk);
      check("t5_done_valid", 32'(b_rsp_valid), 32'd0);
      check("t5_acc_count", 32'(acc_n), 32'd2);
      check("t5_acc_gap", 32'(acc_t[1] - acc_t[0]), 32'd2);
      b_rsp_ready = 1'b0;

      // 6: reset during WAIT discards the response and the committed store
      @(negedge clk);
      a_req_we = 1'b1; a_req_addr = 32'h0000_0040; a_req_be = 4'hF;
      a_req_wdata = 32'hFFFF_FFFF; a_req_valid = 1'b1; a_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_rst_valid", 32'(a_rsp_valid), 32'd0);
      check("t6_rst_ready", 32'(a_req_ready), 32'd0);
      @(negedge clk);
      check("t6_rst_hold_valid", 32'(a_rsp_valid), 32'd0);
      reset = 1'b0;
      a_rsp_ready = 1'b0;
      xact("t6_load40", 1'b0, 32'h0000_0040, 4'h0, 32'd0, 0, 32'h0000_0010, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
